// File: rtl/genome_frame_loader_if.sv
// rtl/genome_frame_loader_if.sv - serial input and per-slot genome outputs of the frame loader
interface genome_frame_loader_if #(
  parameter int DNA_BYTES = 32,
  parameter int NUM_SLOTS = 4
);
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic                             uart_rx;
  logic [32*NUM_SLOTS-1:0]          poly_freq_out;
  logic [8*DNA_BYTES*NUM_SLOTS-1:0] dna_storage;
  logic [NUM_SLOTS-1:0]             otp_en;
  logic [NUM_SLOTS-1:0]             slot_valid;
  logic                             loader_busy;
  logic                             load_done;
  logic [SLOT_W-1:0]                load_slot;
  logic                             frame_err;
  logic [2:0]                       err_code;

  // loader side: consumes the serial line, drives the slot bank
  modport master (
    input  uart_rx,
    output poly_freq_out, dna_storage, otp_en, slot_valid,
    output loader_busy, load_done, load_slot, frame_err, err_code
  );

  // host/core side: drives the serial line, reads the slot bank
  modport slave (
    output uart_rx,
    input  poly_freq_out, dna_storage, otp_en, slot_valid,
    input  loader_busy, load_done, load_slot, frame_err, err_code
  );
endinterface

// File: rtl/genome_frame_loader.sv
// rtl/genome_frame_loader.sv - UART "ATOM" frame parser committing checksummed genomes into slots
module genome_frame_loader #(
  parameter int         CLK_FREQ       = 27000000,
  parameter int         BAUD_RATE      = 115200,
  parameter int         DNA_BYTES      = 32,
  parameter int         NUM_SLOTS      = 4,
  parameter int         TIMEOUT_CYCLES = 270000,
  parameter logic [7:0] VERSION        = 8'h02
) (
  input logic                   clk,
  input logic                   rst_n,
  genome_frame_loader_if.master bus
);
  localparam int CLK_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW      = $clog2(CLK_DIV + 1);
  localparam int SLOT_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int DW      = 8 * DNA_BYTES;
  localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] CH_A = 8'h41;

  // ---------------- UART receiver ----------------
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  rx_state_t     rx_state, rx_nxt;
  logic          rx_meta, rx_sync;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_shift;
  logic          cnt_clr, sample, tick_nxt, ferr_nxt;
  logic          byte_tick, frame_evt;
  logic          half_done, full_done;

  assign half_done = (rx_cnt == CW'(CLK_DIV / 2 - 1));
  assign full_done = (rx_cnt == CW'(CLK_DIV - 1));

  // two-flop synchroniser; resets to the idle-high line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= bus.uart_rx;
      rx_sync <= rx_meta;
    end
  end

  // receiver state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= R_IDLE;
    else        rx_state <= rx_nxt;
  end

  // receiver next state: mid-start check, LSB-first data, stop-bit verdict
  always_comb begin
    rx_nxt   = rx_state;
    cnt_clr  = 1'b0;
    sample   = 1'b0;
    tick_nxt = 1'b0;
    ferr_nxt = 1'b0;
    case (rx_state)
      R_IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_sync) rx_nxt = R_START;
      end
      R_START: begin
        if (half_done) begin
          cnt_clr = 1'b1;
          rx_nxt  = rx_sync ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (full_done) begin
          cnt_clr = 1'b1;
          sample  = 1'b1;
          if (bit_idx == 3'd7) rx_nxt = R_STOP;
        end
      end
      default: begin
        if (full_done) begin
          cnt_clr  = 1'b1;
          rx_nxt   = R_IDLE;
          tick_nxt = rx_sync;
          ferr_nxt = !rx_sync;
        end
      end
    endcase
  end

  // receiver datapath: bit timer, shift register, registered byte/framing pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt    <= '0;
      bit_idx   <= '0;
      rx_shift  <= '0;
      byte_tick <= 1'b0;
      frame_evt <= 1'b0;
    end else begin
      rx_cnt <= cnt_clr ? '0 : rx_cnt + CW'(1);
      if (rx_state == R_START) bit_idx <= '0;
      else if (sample)         bit_idx <= bit_idx + 3'd1;
      if (sample) rx_shift <= {rx_sync, rx_shift[7:1]};
      byte_tick <= tick_nxt;
      frame_evt <= ferr_nxt;
    end
  end

  // ---------------- frame parser ----------------
  typedef enum logic [2:0] {
    P_IDLE, P_MAGIC, P_VERSION, P_SLOT, P_FREQ, P_POLICY, P_DNA, P_CSUM
  } p_state_t;

  p_state_t              p_state, p_nxt;
  logic [7:0]            idx, idx_nxt, xsum, magic_exp;
  logic                  commit, abort, busy, timed_out, take;
  logic [2:0]            abort_code;
  logic [TW-1:0]         to_cnt;
  logic [SLOT_W-1:0]     slot_sel, load_slot_r;
  logic [31:0]           sh_freq;
  logic                  sh_pol;
  logic [DW-1:0]         sh_dna;
  logic [32*NUM_SLOTS-1:0] freq_r;
  logic [DW*NUM_SLOTS-1:0] dna_r;
  logic [NUM_SLOTS-1:0]  otp_r, valid_r;
  logic                  load_done_r, frame_err_r;
  logic [2:0]            err_code_r;

  assign busy      = (p_state != P_IDLE);
  assign timed_out = busy && (to_cnt == TW'(TIMEOUT_CYCLES));
  assign take      = byte_tick && !timed_out;

  always_comb begin
    case (idx[1:0])
      2'd1:    magic_exp = 8'h54;
      2'd2:    magic_exp = 8'h4F;
      default: magic_exp = 8'h4D;
    endcase
  end

  // inter-byte watchdog: runs only inside a frame, restarted by every byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  to_cnt <= '0;
    else if (!busy || byte_tick) to_cnt <= '0;
    else if (!timed_out)         to_cnt <= to_cnt + TW'(1);
  end

  // parser state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p_state <= P_IDLE;
    else        p_state <= p_nxt;
  end

  // parser next state; timeout beats framing beats normal byte handling
  always_comb begin
    p_nxt      = p_state;
    idx_nxt    = idx;
    commit     = 1'b0;
    abort      = 1'b0;
    abort_code = 3'd0;
    if (timed_out) begin
      abort      = 1'b1;
      abort_code = 3'd5;
      p_nxt      = P_IDLE;
      // a byte landing on the timeout edge is treated as arriving in idle
      if (byte_tick && rx_shift == CH_A) begin
        p_nxt   = P_MAGIC;
        idx_nxt = 8'd1;
      end
    end else if (busy && frame_evt) begin
      abort      = 1'b1;
      abort_code = 3'd4;
      p_nxt      = P_IDLE;
    end else if (byte_tick) begin
      case (p_state)
        P_IDLE: begin
          if (rx_shift == CH_A) begin
            p_nxt   = P_MAGIC;
            idx_nxt = 8'd1;
          end
        end
        P_MAGIC: begin
          if (rx_shift == magic_exp) begin
            if (idx == 8'd3) begin
              p_nxt   = P_VERSION;
              idx_nxt = 8'd0;
            end else begin
              idx_nxt = idx + 8'd1;
            end
          end else if (rx_shift == CH_A) begin
            idx_nxt = 8'd1;
          end else begin
            p_nxt = P_IDLE;
          end
        end
        P_VERSION: begin
          if (rx_shift != VERSION) begin
            abort = 1'b1; abort_code = 3'd1; p_nxt = P_IDLE;
          end else begin
            p_nxt = P_SLOT;
          end
        end
        P_SLOT: begin
          if (int'(rx_shift) >= NUM_SLOTS) begin
            abort = 1'b1; abort_code = 3'd2; p_nxt = P_IDLE;
          end else begin
            p_nxt   = P_FREQ;
            idx_nxt = 8'd0;
          end
        end
        P_FREQ: begin
          if (idx == 8'd3) begin
            p_nxt   = P_POLICY;
            idx_nxt = 8'd0;
          end else begin
            idx_nxt = idx + 8'd1;
          end
        end
        P_POLICY: begin
          p_nxt   = P_DNA;
          idx_nxt = 8'd0;
        end
        P_DNA: begin
          if (idx == 8'(DNA_BYTES - 1)) begin
            p_nxt   = P_CSUM;
            idx_nxt = 8'd0;
          end else begin
            idx_nxt = idx + 8'd1;
          end
        end
        default: begin
          p_nxt = P_IDLE;
          if (rx_shift == xsum) commit = 1'b1;
          else begin
            abort = 1'b1; abort_code = 3'd3;
          end
        end
      endcase
    end
  end

  // parser datapath: checksum, shadow capture, atomic slot commit, status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      xsum        <= '0;
      slot_sel    <= '0;
      sh_freq     <= '0;
      sh_pol      <= 1'b0;
      sh_dna      <= '0;
      freq_r      <= '0;
      dna_r       <= '0;
      otp_r       <= '0;
      valid_r     <= '0;
      load_slot_r <= '0;
      load_done_r <= 1'b0;
      frame_err_r <= 1'b0;
      err_code_r  <= '0;
    end else begin
      idx <= idx_nxt;
      if (p_nxt == P_VERSION && p_state != P_VERSION)
        xsum <= '0;
      else if (take && p_state inside {P_VERSION, P_SLOT, P_FREQ, P_POLICY, P_DNA})
        xsum <= xsum ^ rx_shift;
      if (take && p_state == P_SLOT) slot_sel <= rx_shift[SLOT_W-1:0];
      if (take && p_state == P_FREQ)
        for (int i = 0; i < 4; i++)
          if (idx[1:0] == 2'(i)) sh_freq[8*i +: 8] <= rx_shift;
      if (take && p_state == P_POLICY) sh_pol <= rx_shift[0];
      if (take && p_state == P_DNA)
        for (int i = 0; i < DNA_BYTES; i++)
          if (idx == 8'(i)) sh_dna[8*i +: 8] <= rx_shift;
      load_done_r <= commit;
      frame_err_r <= abort;
      if (abort) err_code_r <= abort_code;
      if (commit) begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
          if (slot_sel == SLOT_W'(s)) begin
            freq_r[32*s +: 32] <= sh_freq;
            dna_r[DW*s +: DW]  <= sh_dna;
            otp_r[s]           <= sh_pol;
            valid_r[s]         <= 1'b1;
          end
        end
        load_slot_r <= slot_sel;
      end
    end
  end

  assign bus.poly_freq_out = freq_r;
  assign bus.dna_storage   = dna_r;
  assign bus.otp_en        = otp_r;
  assign bus.slot_valid    = valid_r;
  assign bus.loader_busy   = busy;
  assign bus.load_done     = load_done_r;
  assign bus.load_slot     = load_slot_r;
  assign bus.frame_err     = frame_err_r;
  assign bus.err_code      = err_code_r;
endmodule

// File: tb/tb_genome_frame_loader.sv
// tb/tb_genome_frame_loader.sv - randomized frame stream checked against a slot-bank reference model
module tb_genome_frame_loader;
  localparam int NS = 2;
  localparam int DB = 4;
  localparam int TO = 2000;
  localparam int N  = 12 + DB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  genome_frame_loader_if #(.DNA_BYTES(DB), .NUM_SLOTS(NS)) bus ();

  genome_frame_loader #(
    .CLK_FREQ(1000000), .BAUD_RATE(100000), .DNA_BYTES(DB),
    .NUM_SLOTS(NS), .TIMEOUT_CYCLES(TO), .VERSION(8'h02)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // event log: 16+slot for a commit, 32+code for an abort
  int cyc = 0;
  int ev_q[$];
  int ev_cyc[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.load_done) begin ev_q.push_back(16 + int'(bus.load_slot)); ev_cyc.push_back(cyc); end
    if (bus.frame_err) begin ev_q.push_back(32 + int'(bus.err_code));  ev_cyc.push_back(cyc); end
  end

  // reference slot bank
  logic [31:0]   m_freq[NS];
  logic [31:0]   m_dna[NS];
  logic [NS-1:0] m_pol, m_val;
  logic          m_slot;
  logic [2:0]    m_err;

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin m_freq[s] = '0; m_dna[s] = '0; end
    m_pol = '0; m_val = '0; m_slot = 1'b0; m_err = '0;
  endtask

  // walks the frame byte by byte (frame starts at its 'A'), returns the expected event
  task automatic model_frame(input logic [7:0] f[N], input int sent, input bit bad_last, output int ev);
    logic [7:0] cs;
    int s;
    bit done;
    ev = -1;
    done = 1'b0;
    for (int i = 0; i < sent && !done; i++) begin
      if (bad_last && i == sent - 1) begin ev = (i == 0) ? -1 : 36; done = 1'b1; end
      else if (i == 4 && f[4] != 8'h02) begin ev = 33; done = 1'b1; end
      else if (i == 5 && int'(f[5]) >= NS) begin ev = 34; done = 1'b1; end
      else if (i == N - 1) begin
        cs = 8'h00;
        for (int j = 4; j < N - 1; j++) cs = cs ^ f[j];
        ev = (f[N-1] == cs) ? 16 + int'(f[5]) : 35;
        done = 1'b1;
      end
    end
    if (!done) ev = 37;
    if (ev >= 32) m_err = 3'(ev - 32);
    else if (ev >= 16) begin
      s = int'(f[5]);
      m_freq[s] = {f[9], f[8], f[7], f[6]};
      for (int j = 0; j < DB; j++) m_dna[s][8*j +: 8] = f[11+j];
      m_pol[s] = f[10][0];
      m_val[s] = 1'b1;
      m_slot = 1'(s);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bus.uart_rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rx = b[i];
      repeat (10) @(negedge clk);
    end
    bus.uart_rx = stop;
    repeat (10) @(negedge clk);
    bus.uart_rx = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " freq"},  bus.poly_freq_out, {m_freq[1], m_freq[0]});
    check({tag, " dna"},   bus.dna_storage, {m_dna[1], m_dna[0]});
    check({tag, " otp"},   bus.otp_en, m_pol);
    check({tag, " valid"}, bus.slot_valid, m_val);
    check({tag, " lslot"}, bus.load_slot, m_slot);
    check({tag, " ecode"}, bus.err_code, m_err);
    check({tag, " busy"},  bus.loader_busy, 1'b0);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] pre[$], input logic [7:0] f[N],
                           input int sent, input bit bad_last);
    int ev, last_end, d;
    ev_q.delete();
    ev_cyc.delete();
    foreach (pre[k]) send_byte(pre[k], 1'b1);
    for (int i = 0; i < sent; i++) send_byte(f[i], !(bad_last && i == sent - 1));
    last_end = cyc;
    model_frame(f, sent, bad_last, ev);
    if (ev == 37) begin
      check({tag, " busy_mid"}, bus.loader_busy, 1'b1);
      repeat (TO + 60) @(negedge clk);
    end else begin
      repeat (bad_last ? 200 : 30) @(negedge clk);
    end
    check({tag, " nev"}, ev_q.size(), (ev < 0) ? 0 : 1);
    if (ev >= 0 && ev_q.size() > 0) check({tag, " ev"}, ev_q[0], ev);
    if (ev == 37 && ev_cyc.size() > 0) begin
      d = ev_cyc[0] - last_end;
      check({tag, " to_lat"}, (d > TO - 6 && d < TO + 6), 1'b1);
    end
    check_outputs(tag);
  endtask

  function automatic logic [7:0] rnd_byte();
    logic [7:0] r;
    r = 8'($urandom_range(0, 255));
    if (r == 8'h41) r = 8'h40;
    return r;
  endfunction

  logic [7:0] fr[N];
  logic [7:0] pre[$];
  logic [7:0] nopre[$];
  logic [7:0] cs;
  int kind, sent, pk;
  bit bl;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.uart_rx = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset");
    check("reset done", bus.load_done, 1'b0);
    check("reset ferr", bus.frame_err, 1'b0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    fr = '{8'h41, 8'h54, 8'h4F, 8'h4D, 8'h02, 8'h01, 8'h78, 8'h56,
           8'h34, 8'h12, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h28};
    run_frame("good", nopre, fr, N, 1'b0);
    check("good freq1", bus.poly_freq_out[63:32], 32'h12345678);
    check("good dna1", bus.dna_storage[63:32], 32'hEFBEADDE);
    check("good otp", bus.otp_en, 2'b10);

    fr[N-1] = 8'h29;
    run_frame("csum", nopre, fr, N, 1'b0);
    check("csum code", bus.err_code, 3'd3);

    fr[5] = 8'h02;
    run_frame("slot", nopre, fr, N, 1'b0);
    fr[5] = 8'h00; fr[N-1] = 8'h29;
    run_frame("slot0", nopre, fr, N, 1'b0);

    fr[5] = 8'h01; fr[N-1] = 8'h28;
    run_frame("tmo", nopre, fr, 6, 1'b0);

    pre = '{8'h41};
    run_frame("resync", pre, fr, N, 1'b0);
    run_frame("framing", nopre, fr, 7, 1'b1);

    ev_q.delete();
    for (int i = 0; i < 13; i++) send_byte(fr[i], 1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_mid");
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("rst_mid nev", ev_q.size(), 0);

    for (int t = 0; t < 16; t++) begin
      fr[0] = 8'h41; fr[1] = 8'h54; fr[2] = 8'h4F; fr[3] = 8'h4D;
      fr[4] = 8'h02;
      fr[5] = 8'($urandom_range(0, NS - 1));
      for (int j = 6; j < N - 1; j++) fr[j] = rnd_byte();
      do begin
        cs = 8'h00;
        for (int j = 4; j < N - 1; j++) cs = cs ^ fr[j];
        if (cs == 8'h41) fr[11] = rnd_byte();
      end while (cs == 8'h41);
      fr[N-1] = cs;
      sent = N;
      bl = 1'b0;
      kind = $urandom_range(0, 7);
      case (kind)
        3: fr[4] = 8'($urandom_range(3, 64));
        4: fr[5] = 8'($urandom_range(2, 64));
        5: do fr[N-1] = cs ^ 8'($urandom_range(1, 255)); while (fr[N-1] == 8'h41);
        6: sent = $urandom_range(1, N - 1);
        7: begin sent = $urandom_range(1, N); bl = 1'b1; end
        default: ;
      endcase
      pre.delete();
      pk = $urandom_range(0, 3);
      case (pk)
        1: repeat ($urandom_range(1, 2)) pre.push_back(8'($urandom_range(0, 63)));
        2: pre.push_back(8'h41);
        3: begin pre.push_back(8'h41); pre.push_back(8'h54); pre.push_back(8'($urandom_range(0, 63))); end
        default: ;
      endcase
      run_frame($sformatf("rnd%0d", t), pre, fr, sent, bl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
